// File: rtl/tpu_host_sequencer_if.sv
// Host-side bus bundle for tpu_host_sequencer: program load, run control, TPU instruction/result and capture FIFO.
// Optional repeat_mode signal is present only when TPU_SEQ_REPEAT_EN is defined.
interface tpu_host_sequencer_if #(
   parameter int DEPTH = 16
);
   localparam int PCW = $clog2(DEPTH) + 1;

   logic           load_valid;
   logic           load_ready;
   logic [15:0]    load_word;
   logic           load_cap;
   logic           clear;
   logic           start;
   logic           busy;
   logic           done;
   logic [15:0]    instruction;
   logic [7:0]     result;
   logic           res_valid;
   logic           res_ready;
   logic [7:0]     res_data;
   logic [PCW-1:0] prog_count;
`ifdef TPU_SEQ_REPEAT_EN
   logic           repeat_mode;

   modport master (
      output load_valid, load_word, load_cap, clear, start, result, res_ready, repeat_mode,
      input  load_ready, busy, done, instruction, res_valid, res_data, prog_count
   );

   modport slave (
      input  load_valid, load_word, load_cap, clear, start, result, res_ready, repeat_mode,
      output load_ready, busy, done, instruction, res_valid, res_data, prog_count
   );
`else
   modport master (
      output load_valid, load_word, load_cap, clear, start, result, res_ready,
      input  load_ready, busy, done, instruction, res_valid, res_data, prog_count
   );

   modport slave (
      input  load_valid, load_word, load_cap, clear, start, result, res_ready,
      output load_ready, busy, done, instruction, res_valid, res_data, prog_count
   );
`endif
endinterface

// File: rtl/tpu_host_sequencer.sv
// Buffers a program of 16-bit TPU instructions, replays it one word per cycle and captures flagged
// result bytes into a first-word-fall-through FIFO. Optional looping playback: TPU_SEQ_REPEAT_EN.
module tpu_host_sequencer #(
   parameter int DEPTH     = 16,
   parameter int RES_LAT   = 2,
   parameter int CAP_DEPTH = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   tpu_host_sequencer_if.slave bus
);
   localparam int AW  = $clog2(DEPTH);
   localparam int PCW = AW + 1;
   localparam int LW  = $clog2(RES_LAT + 1);
   localparam int CW  = $clog2(CAP_DEPTH);
   localparam int SW  = $clog2(CAP_DEPTH + RES_LAT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_r, state_s;
   logic [PCW-1:0]     prog_count_r, prog_count_s;
   logic [AW-1:0]      rd_ptr_r, rd_ptr_s;
   logic [LW-1:0]      drain_cnt_r, drain_cnt_s;
   logic [15:0]        instr_r, instr_s;
   logic [RES_LAT-1:0] cap_pipe_r, cap_pipe_s;
   logic               busy_r, done_r, load_ready_r, res_valid_r;
   logic [7:0]         res_data_r, res_data_s;
   logic [16:0]        prog_mem_r [DEPTH];
   logic [7:0]         fifo_mem_r [CAP_DEPTH];
   logic [CW-1:0]      fifo_rd_r, fifo_rd_s, fifo_wr_r, fifo_wr_s;
   logic [CW:0]        fifo_cnt_r, fifo_cnt_s;
   logic               load_we_s, issue_cap_s, fifo_clear_s;
   logic               stall_s, last_s, wrap_s, push_s, pop_s;
   logic [16:0]        entry_s;
   logic [SW-1:0]      reserved_s;

   function automatic logic [SW-1:0] count_ones(input logic [RES_LAT-1:0] v);
      logic [SW-1:0] n;
      n = {SW{1'b0}};
      for (int i = 0; i < RES_LAT; i++) begin
         n = n + SW'(v[i]);
      end
      return n;
   endfunction

`ifdef TPU_SEQ_REPEAT_EN
   assign wrap_s = bus.repeat_mode;
`else
   assign wrap_s = 1'b0;
`endif

   // Captures already in flight reserve FIFO space so a push can never hit a full FIFO
   assign entry_s    = prog_mem_r[rd_ptr_r];
   assign reserved_s = SW'(fifo_cnt_r) + count_ones(cap_pipe_r);
   assign stall_s    = entry_s[16] && (reserved_s >= SW'(CAP_DEPTH));
   assign last_s     = ({1'b0, rd_ptr_r} == (prog_count_r - PCW'(1)));
   assign push_s     = cap_pipe_r[RES_LAT-1];
   assign pop_s      = res_valid_r && bus.res_ready;

   // Sequencer next-state, issue and load decisions
   always_comb begin
      state_s      = state_r;
      prog_count_s = prog_count_r;
      rd_ptr_s     = rd_ptr_r;
      drain_cnt_s  = drain_cnt_r;
      instr_s      = 16'h0000;
      issue_cap_s  = 1'b0;
      load_we_s    = 1'b0;
      fifo_clear_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.clear) begin
               prog_count_s = {PCW{1'b0}};
               fifo_clear_s = 1'b1;
            end else begin
               if (bus.load_valid && load_ready_r) begin
                  load_we_s    = 1'b1;
                  prog_count_s = prog_count_r + PCW'(1);
               end else begin
                  load_we_s    = 1'b0;
               end
               if (bus.start) begin
                  if (prog_count_r != {PCW{1'b0}}) begin
                     state_s  = RUN;
                     rd_ptr_s = {AW{1'b0}};
                  end else begin
                     state_s  = DONE;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
         end
         RUN: begin
            if (stall_s) begin
               instr_s = 16'h0000;
            end else begin
               instr_s     = entry_s[15:0];
               issue_cap_s = entry_s[16];
               if (last_s && wrap_s) begin
                  rd_ptr_s = {AW{1'b0}};
               end else if (last_s) begin
                  state_s     = DRAIN;
                  drain_cnt_s = {LW{1'b0}};
               end else begin
                  rd_ptr_s = rd_ptr_r + AW'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_cnt_r == LW'(RES_LAT)) begin
               state_s = DONE;
            end else begin
               drain_cnt_s = drain_cnt_r + LW'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Capture pipeline shift and result FIFO bookkeeping, including the next FWFT head byte
   always_comb begin
      cap_pipe_s    = cap_pipe_r << 1'b1;
      cap_pipe_s[0] = issue_cap_s;
      fifo_rd_s     = fifo_rd_r;
      fifo_wr_s     = fifo_wr_r;
      fifo_cnt_s    = fifo_cnt_r;
      if (fifo_clear_s) begin
         fifo_rd_s  = {CW{1'b0}};
         fifo_wr_s  = {CW{1'b0}};
         fifo_cnt_s = {(CW+1){1'b0}};
      end else begin
         if (push_s) begin
            fifo_wr_s = fifo_wr_r + CW'(1);
         end else begin
            fifo_wr_s = fifo_wr_r;
         end
         if (pop_s) begin
            fifo_rd_s = fifo_rd_r + CW'(1);
         end else begin
            fifo_rd_s = fifo_rd_r;
         end
         case ({push_s, pop_s})
            2'b10:   fifo_cnt_s = fifo_cnt_r + (CW+1)'(1);
            2'b01:   fifo_cnt_s = fifo_cnt_r - (CW+1)'(1);
            default: fifo_cnt_s = fifo_cnt_r;
         endcase
      end
      if (fifo_cnt_s == {(CW+1){1'b0}}) begin
         res_data_s = 8'h00;
      end else if (push_s && (fifo_wr_r == fifo_rd_s)) begin
         res_data_s = bus.result;
      end else begin
         res_data_s = fifo_mem_r[fifo_rd_s];
      end
   end

   // State, pointers, capture pipeline and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         prog_count_r <= {PCW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         drain_cnt_r  <= {LW{1'b0}};
         instr_r      <= 16'h0000;
         cap_pipe_r   <= {RES_LAT{1'b0}};
         fifo_rd_r    <= {CW{1'b0}};
         fifo_wr_r    <= {CW{1'b0}};
         fifo_cnt_r   <= {(CW+1){1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         load_ready_r <= 1'b1;
         res_valid_r  <= 1'b0;
         res_data_r   <= 8'h00;
      end else begin
         state_r      <= state_s;
         prog_count_r <= prog_count_s;
         rd_ptr_r     <= rd_ptr_s;
         drain_cnt_r  <= drain_cnt_s;
         instr_r      <= instr_s;
         cap_pipe_r   <= cap_pipe_s;
         fifo_rd_r    <= fifo_rd_s;
         fifo_wr_r    <= fifo_wr_s;
         fifo_cnt_r   <= fifo_cnt_s;
         busy_r       <= (state_s == RUN) || (state_s == DRAIN);
         done_r       <= (state_s == DONE);
         load_ready_r <= (state_s == IDLE) && (prog_count_s < PCW'(DEPTH));
         res_valid_r  <= (fifo_cnt_s != {(CW+1){1'b0}});
         res_data_r   <= res_data_s;
      end
   end

   // Program storage; contents are not preserved meaningfully across reset
   always_ff @(posedge clk) begin
      if (load_we_s) begin
         prog_mem_r[prog_count_r[AW-1:0]] <= {bus.load_cap, bus.load_word};
      end
   end

   // Result FIFO storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_mem_r[fifo_wr_r] <= bus.result;
      end
   end

   assign bus.instruction = instr_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.load_ready  = load_ready_r;
   assign bus.res_valid   = res_valid_r;
   assign bus.res_data    = res_data_r;
   assign bus.prog_count  = prog_count_r;
endmodule
